// File: rtl/led_pkg.sv
// Shared definitions for the LED position reader slice.
//   LED_WIDTH   default number of board input lines
//   SAMPLE_DIV  default clk cycles between debounce sample ticks
//   trackState_e  tracker FSM encoding (IDLE, TRACK)
//   clog2       constant-friendly ceiling log2, used to size counters and pos
package led_pkg;

  localparam int LED_WIDTH  = 10;
  localparam int SAMPLE_DIV = 500000;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } trackState_e;

  // Smallest r with 2**r >= value. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchronises a raw input vector, divides clk down to a sample tick and
// accepts a new vector only after STABLE consecutive equal samples.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-low
//   din     in   [WIDTH] raw inputs, asynchronous to clk
//   stable  out  [WIDTH] debounced vector, changes only on a tick
module input_debouncer
  import led_pkg::*;
#(
  parameter int WIDTH  = LED_WIDTH,
  parameter int DIV    = SAMPLE_DIV,
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int DW = (DIV > 1) ? clog2(DIV) : 1;
  localparam int CW = clog2(STABLE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE);
  localparam logic [CW-1:0] CNT_ARM  = CW'(STABLE - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    deb_q, deb_d;
  logic             tick;

  // Divider and whole-vector debounce. The count saturates at STABLE so a
  // long-held vector keeps re-asserting the same stable value harmlessly.
  // deb_q >= STABLE-1 with a matching sample means this sample is the
  // STABLE-th equal one in a row.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + DW'(1);
    cand_d   = cand_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    if (tick) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        deb_d  = CW'(1);
      end else begin
        if (deb_q < CNT_MAX) deb_d = deb_q + CW'(1);
        if (deb_q >= CNT_ARM) stable_d = cand_q;
      end
    end
  end

  // Two-flop synchroniser plus all debounce state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      div_q    <= '0;
      cand_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      cand_q   <= cand_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/led_position_reader.sv
// Reads WIDTH board lines through a debouncer and reports edges, the lit
// position and single-step motion of a one-hot position.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low
//   din        in   [WIDTH] raw inputs
//   stable     out  [WIDTH] debounced vector
//   rise/fall  out  [WIDTH] one-cycle edge pulses of stable
//   pos        out  [PW] highest set bit of stable (0 if none)
//   pos_valid  out  stable != 0
//   onehot     out  exactly one bit of stable set
//   step_up / step_down / jump  out  one-cycle motion pulses
module led_position_reader
  import led_pkg::*;
#(
  parameter int WIDTH  = LED_WIDTH,
  parameter int DIV    = SAMPLE_DIV,
  parameter int STABLE = 4,
  parameter int PW     = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [PW-1:0]    pos,
  output logic             pos_valid,
  output logic             onehot,
  output logic             step_up,
  output logic             step_down,
  output logic             jump
);

  localparam logic [PW:0] ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] prev_q, rise_q, fall_q;
  logic [PW-1:0]    pos_q, posNow, lastPos_q, lastPos_d;
  logic             posValid_q, onehot_q;
  logic             stepUp_q, stepUp_d, stepDown_q, stepDown_d, jump_q, jump_d;
  logic             onehotNow, changed;
  trackState_e      state_q, state_d;

  input_debouncer #(
    .WIDTH  (WIDTH),
    .DIV    (DIV),
    .STABLE (STABLE)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .stable (stable)
  );

  // Combinational view of the current stable vector; the outputs below are
  // registered copies so they line up with rise/fall.
  always_comb begin
    posNow = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (stable[i]) posNow = PW'(i);
    end
    onehotNow = $onehot(stable);
    changed   = (stable != prev_q);
  end

  // Tracker next state. Only reacts in the cycle after stable moved, so each
  // accepted vector yields at most one motion pulse. Comparisons are done one
  // bit wider so last_pos = 0 or WIDTH-1 cannot wrap into a false step.
  always_comb begin
    state_d    = state_q;
    lastPos_d  = lastPos_q;
    stepUp_d   = 1'b0;
    stepDown_d = 1'b0;
    jump_d     = 1'b0;
    if (changed) begin
      case (state_q)
        IDLE: begin
          if (onehotNow) begin
            state_d   = TRACK;
            lastPos_d = posNow;
          end
        end
        TRACK: begin
          if (!onehotNow) begin
            state_d = IDLE;
          end else begin
            if ({1'b0, posNow} == {1'b0, lastPos_q} + ONE) stepUp_d = 1'b1;
            else if ({1'b0, posNow} + ONE == {1'b0, lastPos_q}) stepDown_d = 1'b1;
            else jump_d = 1'b1;
            lastPos_d = posNow;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge detection, registered position flags and tracker state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      pos_q      <= '0;
      posValid_q <= 1'b0;
      onehot_q   <= 1'b0;
      stepUp_q   <= 1'b0;
      stepDown_q <= 1'b0;
      jump_q     <= 1'b0;
      lastPos_q  <= '0;
      state_q    <= IDLE;
    end else begin
      prev_q     <= stable;
      rise_q     <= stable & ~prev_q;
      fall_q     <= ~stable & prev_q;
      pos_q      <= posNow;
      posValid_q <= (stable != '0);
      onehot_q   <= onehotNow;
      stepUp_q   <= stepUp_d;
      stepDown_q <= stepDown_d;
      jump_q     <= jump_d;
      lastPos_q  <= lastPos_d;
      state_q    <= state_d;
    end
  end

  assign rise      = rise_q;
  assign fall      = fall_q;
  assign pos       = pos_q;
  assign pos_valid = posValid_q;
  assign onehot    = onehot_q;
  assign step_up   = stepUp_q;
  assign step_down = stepDown_q;
  assign jump      = jump_q;

endmodule

// File: tb/tb_led_position_reader.sv
// Self-checking bench for led_position_reader with DIV=4, STABLE=3, WIDTH=10.
// A behavioural model (sample history queue, integer position arithmetic)
// predicts every output each cycle; directed scenarios add targeted checks.
module tb_led_position_reader;

  localparam int WIDTH  = 10;
  localparam int DIV    = 4;
  localparam int STABLE = 3;
  localparam int PW     = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] stable, rise, fall;
  logic [PW-1:0]    pos;
  logic             pos_valid, onehot, step_up, step_down, jump;

  led_position_reader #(
    .WIDTH (WIDTH), .DIV (DIV), .STABLE (STABLE), .PW (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .stable    (stable),
    .rise      (rise),
    .fall      (fall),
    .pos       (pos),
    .pos_valid (pos_valid),
    .onehot    (onehot),
    .step_up   (step_up),
    .step_down (step_down),
    .jump      (jump)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model state
  logic [WIDTH-1:0] mS1, mS2, mStable, mPrev, mRise, mFall;
  logic [WIDTH-1:0] samples[$];
  int               mPos, lastPos, edgeCnt;
  bit               mValid, mOnehot, mUp, mDown, mJump, tracking;

  // Observed pulse statistics from the DUT
  int               obsUp = 0, obsDown = 0, obsJump = 0, obsRiseEv = 0, obsFallEv = 0;
  logic [WIDTH-1:0] lastRise = '0, lastFall = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic int highestBit(input logic [WIDTH-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mStable = '0; mPrev = '0; mRise = '0; mFall = '0;
    samples.delete();
    mPos = 0; lastPos = 0; edgeCnt = 0;
    mValid = 0; mOnehot = 0; mUp = 0; mDown = 0; mJump = 0; tracking = 0;
  endtask

  // One clock edge of the reference: a new stable vector is accepted once the
  // last STABLE tick samples are identical; the outputs describe the stable
  // vector as it was before this edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] dinNow);
    bit               isTick, allSame;
    logic [WIDTH-1:0] newStable;
    int               p, delta;
    isTick    = ((edgeCnt % DIV) == DIV - 1);
    newStable = mStable;
    if (isTick) begin
      samples.push_back(mS2);
      if (samples.size() > STABLE) void'(samples.pop_front());
      if (samples.size() == STABLE) begin
        allSame = 1;
        foreach (samples[k]) if (samples[k] != samples[0]) allSame = 0;
        if (allSame) newStable = samples[0];
      end
    end
    mRise   = mStable & ~mPrev;
    mFall   = ~mStable & mPrev;
    mPos    = highestBit(mStable);
    mValid  = (mStable != 0);
    mOnehot = ($countones(mStable) == 1);
    mUp = 0; mDown = 0; mJump = 0;
    if (mStable != mPrev) begin
      p = highestBit(mStable);
      if (!tracking) begin
        if (mOnehot) begin
          tracking = 1;
          lastPos  = p;
        end
      end else if (!mOnehot) begin
        tracking = 0;
      end else begin
        delta = p - lastPos;
        if (delta == 1) mUp = 1;
        else if (delta == -1) mDown = 1;
        else mJump = 1;
        lastPos = p;
      end
    end
    mPrev   = mStable;
    mStable = newStable;
    mS2     = mS1;
    mS1     = dinNow;
    edgeCnt++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    applyStimulus(din);
    checkOutput("stable", 32'(stable), 32'(mStable));
    checkOutput("rise", 32'(rise), 32'(mRise));
    checkOutput("fall", 32'(fall), 32'(mFall));
    checkOutput("pos", 32'(pos), 32'(mPos));
    checkOutput("flags", {27'd0, pos_valid, onehot, step_up, step_down, jump},
                {27'd0, mValid, mOnehot, mUp, mDown, mJump});
    if (step_up) obsUp++;
    if (step_down) obsDown++;
    if (jump) obsJump++;
    if (rise != 0) begin obsRiseEv++; lastRise = rise; end
    if (fall != 0) begin obsFallEv++; lastFall = fall; end
  endtask

  task automatic holdTicks(input int n);
    for (int c = 0; c < n * DIV; c++) stepCycle();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_vec"}, {2'd0, stable, rise, fall}, 32'd0);
    checkOutput({tag, "_flags"}, {23'd0, pos, pos_valid, onehot, step_up, step_down, jump}, 32'd0);
  endtask

  initial begin
    int latency, up0, down0, jump0, rise0, fall0, curPos, mode, holdLen;
    logic [WIDTH-1:0] nextVal;
    modelReset();
    #12 reset = 1'b1;

    // Reset mid-count with stable = 0x010, then first tick DIV cycles later
    din = 10'h010;
    holdTicks(6);
    checkOutput("preResetStable", 32'(stable), 32'h010);
    reset = 1'b0;
    #2;
    checkResetOutputs("asyncReset");
    modelReset();
    #2 reset = 1'b1;
    latency = 40;
    for (int i = 1; i <= 40; i++) begin
      stepCycle();
      if (rise != 0) begin latency = i; break; end
    end
    checkOutput("reentryLatency", 32'(latency), 32'd13);
    checkOutput("reentryRise", 32'(rise), 32'h010);

    // 0x000 -> 0x001: rise and IDLE -> TRACK with no motion pulse
    din = 10'h000;
    holdTicks(5);
    up0 = obsUp; down0 = obsDown; jump0 = obsJump;
    din = 10'h001;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (rise != 0) break;
    end
    checkOutput("firstRise", 32'(rise), 32'h001);
    checkOutput("firstPos", {27'd0, pos, pos_valid}, {27'd0, 4'd0, 1'b1});
    checkOutput("firstOnehot", 32'(onehot), 32'd1);
    holdTicks(2);
    checkOutput("firstNoPulse", 32'(obsUp - up0 + obsDown - down0 + obsJump - jump0), 32'd0);

    // Bounce every tick: stable must not move
    rise0 = obsRiseEv; fall0 = obsFallEv;
    for (int t = 0; t < 8; t++) begin
      din = din ^ 10'h001;
      holdTicks(1);
    end
    holdTicks(4);
    checkOutput("bounceStable", 32'(stable), 32'h001);
    checkOutput("bounceEdges", 32'(obsRiseEv - rise0 + obsFallEv - fall0), 32'd0);

    // Walk up to the top, then one step back down
    up0 = obsUp;
    for (int i = 1; i < WIDTH; i++) begin
      din = 10'(1 << i);
      holdTicks(4);
    end
    checkOutput("walkUpCount", 32'(obsUp - up0), 32'd9);
    checkOutput("walkPos", 32'(pos), 32'd9);
    down0 = obsDown;
    din = 10'h100;
    holdTicks(4);
    checkOutput("stepDownCount", 32'(obsDown - down0), 32'd1);
    checkOutput("stepDownFall", 32'(lastFall), 32'h200);
    checkOutput("stepDownRise", 32'(lastRise), 32'h100);

    // Jumps, including no wrap-around from the top to bit 0
    din = 10'h004;
    holdTicks(5);
    up0 = obsUp; down0 = obsDown; jump0 = obsJump;
    din = 10'h040;
    holdTicks(5);
    checkOutput("jumpCount", 32'(obsJump - jump0), 32'd1);
    checkOutput("jumpNoStep", 32'(obsUp - up0 + obsDown - down0), 32'd0);
    checkOutput("jumpPos", 32'(pos), 32'd6);
    din = 10'h200;
    holdTicks(5);
    up0 = obsUp; down0 = obsDown; jump0 = obsJump;
    din = 10'h001;
    holdTicks(5);
    checkOutput("wrapJump", 32'(obsJump - jump0), 32'd1);
    checkOutput("wrapNoStep", 32'(obsUp - up0 + obsDown - down0), 32'd0);

    // Two bits set drops to IDLE; re-entry gives no pulse
    din = 10'h002;
    holdTicks(5);
    up0 = obsUp; down0 = obsDown; jump0 = obsJump;
    din = 10'h003;
    holdTicks(5);
    checkOutput("multiOnehot", 32'(onehot), 32'd0);
    checkOutput("multiPos", {27'd0, pos, pos_valid}, {27'd0, 4'd1, 1'b1});
    din = 10'h002;
    holdTicks(5);
    checkOutput("reentryNoPulse", 32'(obsUp - up0 + obsDown - down0 + obsJump - jump0), 32'd0);

    // Randomised segments: neighbours, arbitrary one-hots, arbitrary vectors,
    // zero, short glitches, and one asynchronous reset in the middle
    for (int seg = 0; seg < 300; seg++) begin
      curPos = highestBit(din);
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin
          if ($urandom_range(0, 1) == 1) curPos = (curPos < WIDTH - 1) ? curPos + 1 : curPos - 1;
          else curPos = (curPos > 0) ? curPos - 1 : curPos + 1;
          nextVal = 10'(1 << curPos);
        end
        1: nextVal = 10'(1 << $urandom_range(0, WIDTH - 1));
        2: nextVal = 10'($urandom);
        3: nextVal = '0;
        default: nextVal = din ^ 10'(1 << $urandom_range(0, WIDTH - 1));
      endcase
      din = nextVal;
      holdLen = (mode == 4) ? $urandom_range(1, 2 * DIV) : $urandom_range(DIV, 6 * DIV);
      for (int c = 0; c < holdLen; c++) stepCycle();
      if (seg == 150) begin
        reset = 1'b0;
        #($urandom_range(1, 3));
        checkResetOutputs("randReset");
        modelReset();
        #2 reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
